// File: rtl/pillar_pkg.sv
// Shared definitions for the integer register file slice: default sizes,
// address/data word types and the hardwired-zero register index.
package pillar_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage : pillar_pkg

// File: rtl/regfile_rdport.sv
// Single register file read port: selects one word out of the flattened data
// array, gates register 0 to zero and reports the pending-write (busy) flag.
// With REGFILE_BYPASS_EN defined, a same-cycle writeback to the addressed
// register is forwarded straight to the output and clears the busy flag.
import pillar_pkg::*;

module regfile_rdport #(
  parameter int XLEN  = pillar_pkg::XLEN,
  parameter int NREGS = pillar_pkg::NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [AW-1:0]         rd_addr_i,
  input  logic [NREGS*XLEN-1:0] mem_flat_i,
  input  logic [NREGS-1:0]      busy_i,
`ifdef REGFILE_BYPASS_EN
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [XLEN-1:0]       wr_data_i,
`endif
  output logic [XLEN-1:0]       rd_data_o,
  output logic                  rd_busy_o
);

  // Read mux with register-0 gating and optional writeback forwarding
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = 1'b0;
    if (rd_addr_i == REG_ZERO) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end else begin
      rd_data_o = mem_flat_i[rd_addr_i*XLEN +: XLEN];
      rd_busy_o = busy_i[rd_addr_i];
`ifdef REGFILE_BYPASS_EN
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
        rd_data_o = wr_data_i;
        rd_busy_o = 1'b0;
      end else begin
        rd_data_o = mem_flat_i[rd_addr_i*XLEN +: XLEN];
        rd_busy_o = busy_i[rd_addr_i];
      end
`endif
    end
  end

endmodule : regfile_rdport

// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard for decode.
// NRD combinational read ports, one writeback port, issue-time destination
// allocation and a flush that drops every pending claim. Register 0 reads as
// zero and is never marked busy. Optional write-to-read forwarding is enabled
// by defining REGFILE_BYPASS_EN.
import pillar_pkg::*;

module regfile_sb #(
  parameter int XLEN  = pillar_pkg::XLEN,
  parameter int NREGS = pillar_pkg::NREGS,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS),
  localparam int CW   = $clog2(NREGS+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  alloc_en,
  input  logic [AW-1:0]         alloc_addr,
  output logic                  alloc_ready,
  input  logic                  flush,
  output logic [CW-1:0]         busy_cnt
);

  logic [NREGS*XLEN-1:0] mem_q;
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_d;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  alloc_ready_s;
  logic                  wr_valid_s;

  assign wr_valid_s  = wr_en && (wr_addr != REG_ZERO);
  assign alloc_ready = alloc_ready_s;
  assign busy_cnt    = cnt_q;

  // Claim acceptance: free, zero, or being released by this cycle's writeback
  always_comb begin
    alloc_ready_s = 1'b0;
    if (flush) begin
      alloc_ready_s = 1'b0;
    end else if (alloc_addr == REG_ZERO) begin
      alloc_ready_s = 1'b1;
    end else if (!busy_q[alloc_addr]) begin
      alloc_ready_s = 1'b1;
    end else if (wr_en && (wr_addr == alloc_addr)) begin
      alloc_ready_s = 1'b1;
    end else begin
      alloc_ready_s = 1'b0;
    end
  end

  // Next busy vector: flush clears all; otherwise writeback clears, alloc sets (alloc wins)
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_valid_s) begin
        busy_d[wr_addr] = 1'b0;
      end else begin
        busy_d = busy_q;
      end
      if (alloc_en && alloc_ready_s && (alloc_addr != REG_ZERO)) begin
        busy_d[alloc_addr] = 1'b1;
      end else begin
        busy_d[alloc_addr] = busy_d[alloc_addr];
      end
    end
    busy_d[0] = 1'b0;
  end

  // Population count of the next busy vector so the registered count has no lag
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + CW'(busy_d[i]);
    end
  end

  // State update: data array, busy vector and busy count
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q  <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_valid_s) begin
        mem_q[wr_addr*XLEN +: XLEN] <= wr_data;
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rdport
    regfile_rdport #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_rdport (
      .rd_addr_i  (rd_addr[g*AW +: AW]),
      .mem_flat_i (mem_q),
      .busy_i     (busy_q),
`ifdef REGFILE_BYPASS_EN
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
`endif
      .rd_data_o  (rd_data[g*XLEN +: XLEN]),
      .rd_busy_o  (rd_busy[g])
    );
  end

endmodule : regfile_sb
